// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the ALU (req0) and the load unit (req1).
// Each requester has a one-entry buffer. A round-robin arbiter drains the buffers into a registered write stage.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_dest,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_dest,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  reg_write_en,
    output logic [ADDR_WIDTH-1:0] reg_write_dest,
    output logic [DATA_WIDTH-1:0] reg_write_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr_1,
    input  logic [ADDR_WIDTH-1:0] rd_addr_2,
    output logic                  hazard_1,
    output logic                  hazard_2
);

    logic [1:0]            valid;
    logic [1:0]            ready;
    logic [1:0]            accept;
    logic [1:0]            grant;
    logic [1:0]            hazard;
    logic [ADDR_WIDTH-1:0] dest_in [2];
    logic [DATA_WIDTH-1:0] data_in [2];
    logic [ADDR_WIDTH-1:0] rd_addr [2];

    logic [1:0]            occ_reg;
    logic [ADDR_WIDTH-1:0] buf_dest_reg [2];
    logic [DATA_WIDTH-1:0] buf_data_reg [2];
    logic                  rr_ptr_reg;

    logic [ADDR_WIDTH-1:0] sel_dest;
    logic [DATA_WIDTH-1:0] sel_data;

    assign valid      = {req1_valid, req0_valid};
    assign dest_in[0] = req0_dest;
    assign dest_in[1] = req1_dest;
    assign data_in[0] = req0_data;
    assign data_in[1] = req1_data;
    assign rd_addr[0] = rd_addr_1;
    assign rd_addr[1] = rd_addr_2;

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign hazard_1   = hazard[0];
    assign hazard_2   = hazard[1];

    // A lone occupied buffer always wins; rr_ptr only breaks ties.
    always_comb begin
        grant = occ_reg;
        if (occ_reg == 2'b11) begin
            grant = rr_ptr_reg ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        sel_dest = buf_dest_reg[0];
        sel_data = buf_data_reg[0];
        if (grant[1]) begin
            sel_dest = buf_dest_reg[1];
            sel_data = buf_data_reg[1];
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            // A buffer being drained this cycle can be refilled at the same edge.
            assign ready[gi]  = ~rst & (~occ_reg[gi] | grant[gi]);
            assign accept[gi] = valid[gi] & ready[gi];

            assign hazard[gi] = ~rst & (
                  (occ_reg[0]   && (buf_dest_reg[0] == rd_addr[gi]))
                | (occ_reg[1]   && (buf_dest_reg[1] == rd_addr[gi]))
                | (reg_write_en && (reg_write_dest  == rd_addr[gi])));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_reg <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                buf_dest_reg[i] <= '0;
                buf_data_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (accept[i]) begin
                    occ_reg[i]      <= 1'b1;
                    buf_dest_reg[i] <= dest_in[i];
                    buf_data_reg[i] <= data_in[i];
                end else if (grant[i]) begin
                    occ_reg[i] <= 1'b0;
                end
            end
        end
    end

    // Pointer advances to the loser only when both buffers actually competed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= 1'b0;
        end else if (occ_reg == 2'b11) begin
            rr_ptr_reg <= grant[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_en   <= 1'b0;
            reg_write_dest <= '0;
            reg_write_data <= '0;
        end else begin
            reg_write_en <= |grant;
            if (|grant) begin
                reg_write_dest <= sel_dest;
                reg_write_data <= sel_data;
            end
        end
    end

endmodule
